// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatcher and its picker.
// Pointer width for a given channel count is $clog2(N); PW_MAX covers the largest build.
package rr_dispatch_pkg;

    localparam int N_MAX  = 8;
    localparam int PW_MAX = $clog2(N_MAX);

    typedef enum logic {
        PICK_WORK   = 1'b0,
        PICK_STRICT = 1'b1
    } pick_mode_e;

    function automatic logic [N_MAX-1:0] onehot(input logic [PW_MAX-1:0] idx);
        logic [N_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next index in rotation for a ring of n entries.
    function automatic logic [PW_MAX-1:0] wrap_inc(input logic [PW_MAX-1:0] idx,
                                                    input int unsigned      n);
        logic [PW_MAX-1:0] nxt;
        if (32'(idx) + 32'd1 >= n)
            nxt = '0;
        else
            nxt = idx + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_dispatch_pick.sv
// rr_pick: combinational rotating-priority picker. Scans free channels starting
// at the pointer; in strict mode only the pointer channel is a candidate.
module rr_pick
    import rr_dispatch_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_free,
    input  logic [PW-1:0] i_ptr,
    input  pick_mode_e    i_mode,
    output logic          o_found,
    output logic [PW-1:0] o_sel,
    output logic [N-1:0]  o_sel_oh
);

    localparam logic [PW:0] NV = (PW+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic [PW-1:0]  w_off;
    logic           w_found;
    logic [PW:0]    w_sum;

    // Rotate so that bit k of w_rot is channel (ptr + k) mod N.
    assign w_dbl   = {i_free, i_free};
    assign w_shift = w_dbl >> i_ptr;
    assign w_rot   = w_shift[N-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k] && (i_mode == PICK_WORK || k == 0)) begin
                w_found = 1'b1;
                w_off   = PW'(k);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= NV)
            w_sum = w_sum - NV;
    end

    assign o_found  = w_found;
    assign o_sel    = w_sum[PW-1:0];
    assign o_sel_oh = w_found ? N'(onehot(PW_MAX'(w_sum[PW-1:0]))) : '0;

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one valid/ready stream spread over N one-entry channel buffers.
// Define RR_DISPATCH_STRICT_EN for strict rotation (item i always to channel i mod N).
module rr_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              en,
    input  logic              in_vld,
    input  logic [DW-1:0]     in_data,
    output logic              in_rdy,
    output logic [N-1:0]      out_vld,
    output logic [N*DW-1:0]   out_data,
    input  logic [N-1:0]      out_rdy,
    output logic [N-1:0]      o_sel,
    output logic [CW-1:0]     o_cnt
);

    localparam int PW = $clog2(N);

`ifdef RR_DISPATCH_STRICT_EN
    localparam pick_mode_e MODE = PICK_STRICT;
`else
    localparam pick_mode_e MODE = PICK_WORK;
`endif

    if (N < 2 || N > N_MAX) begin : g_bad_n
        $error("rr_dispatcher: N must be in 2..%0d", N_MAX);
    end

    logic [PW-1:0]             r_ptr;
    logic [N-1:0]              r_vld;
    logic [N-1:0][DW-1:0]      r_data;
    logic [N-1:0]              r_sel;
    logic [CW-1:0]             r_cnt;

    logic [N-1:0]              w_free;
    logic                      w_found;
    logic [PW-1:0]             w_sel;
    logic [N-1:0]              w_sel_oh;
    logic                      w_acc;

    // A channel draining this cycle can take a new item in the same cycle.
    assign w_free = ~r_vld | out_rdy;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_free   (w_free),
        .i_ptr    (r_ptr),
        .i_mode   (MODE),
        .o_found  (w_found),
        .o_sel    (w_sel),
        .o_sel_oh (w_sel_oh)
    );

    assign in_rdy = en & w_found;
    assign w_acc  = in_vld & in_rdy;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_ptr  <= '0;
            r_vld  <= '0;
            r_data <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_acc) begin
                r_ptr <= PW'(wrap_inc(PW_MAX'(w_sel), N));
                r_sel <= w_sel_oh;
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_sel <= '0;
            end
            for (int i = 0; i < N; i++) begin
                if (w_acc && w_sel_oh[i]) begin
                    r_vld[i]  <= 1'b1;
                    r_data[i] <= in_data;
                end else if (out_rdy[i]) begin
                    r_vld[i]  <= 1'b0;
                end
            end
        end
    end

    assign out_vld  = r_vld;
    assign out_data = r_data;
    assign o_sel    = r_sel;
    assign o_cnt    = r_cnt;

endmodule
